// File: rtl/register_file_pkg.sv
// Shared types and helpers for the W0RM multi-port register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package register_file_pkg;

  // Clear sequencer states: CLEAR zeroes one register per edge, IDLE serves traffic.
  typedef enum logic {
    RF_CLEAR,
    RF_IDLE
  } rf_state_t;

  // Widest read-port configuration the file supports.
  localparam int RF_MAX_READ_PORTS = 4;

  // Address width needed to index `value` entries (value >= 2).
  function automatic int rf_clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: address mux with range check, optional
// same-cycle write forwarding, and the rd_data/rd_valid output register.
// Optional feature macro: REGFILE_BYPASS_EN.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REGISTERS = 4,
  parameter int ADDR_WIDTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ready_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] regs_i [NUM_REGISTERS],
`ifdef REGFILE_BYPASS_EN
  input  logic                  wr0_commit_i,
  input  logic [ADDR_WIDTH-1:0] wr0_addr_i,
  input  logic [DATA_WIDTH-1:0] wr0_data_i,
  input  logic                  wr1_commit_i,
  input  logic [ADDR_WIDTH-1:0] wr1_addr_i,
  input  logic [DATA_WIDTH-1:0] wr1_data_i,
`endif
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // Select the addressed register; out-of-range addresses read as zero.
  always_comb begin
    rd_data_d = '0;
    if (32'(rd_addr_i) < NUM_REGISTERS) begin
      rd_data_d = regs_i[rd_addr_i];
    end
`ifdef REGFILE_BYPASS_EN
    // Commits are already range-checked, so a match implies a valid address.
    // Port 1 is tested last so it wins when both ports hit.
    if (wr0_commit_i && (wr0_addr_i == rd_addr_i)) begin
      rd_data_d = wr0_data_i;
    end
    if (wr1_commit_i && (wr1_addr_i == rd_addr_i)) begin
      rd_data_d = wr1_data_i;
    end
`endif
  end

  // Output register: zero while not ready, load on request, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (!ready_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en_i) begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports (port 1 wins on conflict),
// READ_PORTS registered read ports and a clear sequencer that zeroes the
// array after reset or on request.
// Optional feature macro: REGFILE_BYPASS_EN (write-before-read forwarding).
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REGISTERS = 4,
  parameter int READ_PORTS    = 2,
  localparam int ADDR_WIDTH   = rf_clog2(NUM_REGISTERS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  output logic                             ready,
  input  logic                             wr0_en,
  input  logic [ADDR_WIDTH-1:0]            wr0_addr,
  input  logic [DATA_WIDTH-1:0]            wr0_data,
  input  logic                             wr1_en,
  input  logic [ADDR_WIDTH-1:0]            wr1_addr,
  input  logic [DATA_WIDTH-1:0]            wr1_data,
  input  logic [READ_PORTS-1:0]            rd_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]            rd_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGISTERS - 1);

  rf_state_t             state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGISTERS];

  logic wr0_commit;
  logic wr1_commit;

  // A write lands only while serving traffic and only for an existing register.
  assign wr0_commit = ready_q && wr0_en && (32'(wr0_addr) < NUM_REGISTERS);
  assign wr1_commit = ready_q && wr1_en && (32'(wr1_addr) < NUM_REGISTERS);
  assign ready      = ready_q;

  // Clear sequencer: walk clr_cnt over every register, then serve until cleared again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q   <= RF_IDLE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        RF_IDLE: begin
          if (clear) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= RF_CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: sequencer zeroing while clearing, else port writes with port 1 last.
  always_ff @(posedge clk) begin
    if (state_q == RF_CLEAR) begin
      regs_q[clr_cnt_q] <= '0;
    end else begin
      if (wr0_commit) begin
        regs_q[wr0_addr] <= wr0_data;
      end
      if (wr1_commit) begin
        regs_q[wr1_addr] <= wr1_data;
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd_port
    if (gi < RF_MAX_READ_PORTS) begin : g_port
      register_file_read_port #(
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_REGISTERS(NUM_REGISTERS),
        .ADDR_WIDTH   (ADDR_WIDTH)
      ) u_read_port (
        .clk         (clk),
        .reset_n     (reset_n),
        .ready_i     (ready_q),
        .rd_en_i     (rd_en[gi]),
        .rd_addr_i   (rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
        .regs_i      (regs_q),
`ifdef REGFILE_BYPASS_EN
        .wr0_commit_i(wr0_commit),
        .wr0_addr_i  (wr0_addr),
        .wr0_data_i  (wr0_data),
        .wr1_commit_i(wr1_commit),
        .wr1_addr_i  (wr1_addr),
        .wr1_data_i  (wr1_data),
`endif
        .rd_data_o   (rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .rd_valid_o  (rd_valid[gi])
      );
    end else begin : g_unsupported
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      assign rd_valid[gi]                         = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp. Two instances share one stimulus
// stream: inst0 has 4 registers (2-bit addresses, low address bits), inst1
// has 5 registers (3-bit addresses, exercises out-of-range accesses).
// Honours REGFILE_BYPASS_EN in its reference model.
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       clear;
  logic       wr0_en, wr1_en;
  logic [2:0] wr0_addr, wr1_addr;
  logic [7:0] wr0_data, wr1_data;
  logic [1:0] rd_en;
  logic [2:0] ra0, ra1;

  logic        ready_a, ready_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;

  register_file_mp #(.DATA_WIDTH(8), .NUM_REGISTERS(4), .READ_PORTS(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready_a),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr[1:0]), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr[1:0]), .wr1_data(wr1_data),
    .rd_en(rd_en), .rd_addr({ra1[1:0], ra0[1:0]}),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  register_file_mp #(.DATA_WIDTH(8), .NUM_REGISTERS(5), .READ_PORTS(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ready(ready_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_en(rd_en), .rd_addr({ra1, ra0}),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, remaining clear edges, ready flag.
  logic [7:0] mem [2][8];
  int         busy [2];
  bit         mready [2];

  // Expected read data per (instance*2 + port), expected ready per instance.
  logic [7:0] exp_rd_q [4][$];
  bit         exp_ready_q [2][$];

  function automatic int nregs(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  // Address as seen by instance k (inst0 only gets the low two bits).
  function automatic int eff(input int k, input logic [2:0] a);
    logic [2:0] t;
    t = a;
    return (k == 0) ? int'(t[1:0]) : int'(t);
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = nregs(k);
      if (!reset_n) begin
        busy[k]   = n;
        mready[k] = 1'b0;
      end else if (!mready[k]) begin
        busy[k]--;
        if (busy[k] == 0) begin
          for (int i = 0; i < 8; i++) mem[k][i] = 8'h00;
          mready[k] = 1'b1;
        end
      end else begin
        int a0, a1;
        for (int p = 0; p < 2; p++) begin
          if (rd_en[p]) begin
            int a;
            logic [7:0] v;
            a = eff(k, (p == 0) ? ra0 : ra1);
            v = (a < n) ? mem[k][a] : 8'h00;
`ifdef REGFILE_BYPASS_EN
            if (a < n) begin
              if (wr1_en && eff(k, wr1_addr) == a) v = wr1_data;
              else if (wr0_en && eff(k, wr0_addr) == a) v = wr0_data;
            end
`endif
            exp_rd_q[k*2+p].push_back(v);
          end
        end
        a0 = eff(k, wr0_addr);
        a1 = eff(k, wr1_addr);
        if (wr0_en && a0 < n) mem[k][a0] = wr0_data;
        if (wr1_en && a1 < n) mem[k][a1] = wr1_data;
        if (clear) begin
          busy[k]   = n;
          mready[k] = 1'b0;
        end
      end
      exp_ready_q[k].push_back(mready[k]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0;
    wr0_addr = 3'd0; wr1_addr = 3'd0; wr0_data = 8'h00; wr1_data = 8'h00;
    rd_en = 2'b00; ra0 = 3'd0; ra1 = 3'd0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      idle_inputs();
      rd_en = 2'b11; ra0 = 3'(a); ra1 = 3'(7 - a);
      tick();
    end
    idle_inputs();
  endtask

  // Monitor: compare ready every cycle and each presented read against the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (exp_ready_q[k].size() > 0) begin
        bit er;
        logic got;
        er  = exp_ready_q[k].pop_front();
        got = (k == 0) ? ready_a : ready_b;
        checks++;
        if (got !== er) begin
          errors++;
          $display("FAIL ready inst%0d t=%0t: got %b expected %b", k, $time, got, er);
        end
      end
      for (int p = 0; p < 2; p++) begin
        logic       v;
        logic [7:0] d;
        v = (k == 0) ? rd_valid_a[p] : rd_valid_b[p];
        d = (k == 0) ? rd_data_a[p*8 +: 8] : rd_data_b[p*8 +: 8];
        if (v !== 1'b0) begin
          checks++;
          if (exp_rd_q[k*2+p].size() == 0) begin
            errors++;
            $display("FAIL rd_valid inst%0d port%0d t=%0t: got valid=%b data=%02h expected no read", k, p, $time, v, d);
          end else begin
            logic [7:0] e;
            e = exp_rd_q[k*2+p].pop_front();
            if (d !== e) begin
              errors++;
              $display("FAIL rd_data inst%0d port%0d t=%0t: got %02h expected %02h", k, p, $time, d, e);
            end else begin
              $display("read inst%0d port%0d data=%02h ok", k, p, d);
            end
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    reset_n = 1'b1;
    // Clear sequence after reset: ready low for NUM_REGISTERS edges.
    repeat (6) tick();
    read_all();

    // Basic write on port 0, read next cycle on port 1.
    wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 8'hA5; tick();
    idle_inputs(); rd_en = 2'b10; ra1 = 3'd2; tick();
    idle_inputs(); tick();

    // Both ports write the same register: port 1 wins.
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 8'h11;
    wr1_en = 1'b1; wr1_addr = 3'd1; wr1_data = 8'h22; tick();
    idle_inputs(); rd_en = 2'b01; ra0 = 3'd1; tick();

    // Same-cycle read and write of one register.
    idle_inputs(); wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 8'h0F; tick();
    idle_inputs(); wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 8'hF0;
    rd_en = 2'b01; ra0 = 3'd3; tick();
    idle_inputs(); rd_en = 2'b11; ra0 = 3'd3; ra1 = 3'd3; tick();

    // Fill with 0xFF, then a one-cycle clear with a write issued while clearing.
    for (int a = 0; a < 5; a += 2) begin
      idle_inputs();
      wr0_en = 1'b1; wr0_addr = 3'(a);     wr0_data = 8'hFF;
      wr1_en = 1'b1; wr1_addr = 3'(a + 1); wr1_data = 8'hFF;
      tick();
    end
    idle_inputs(); clear = 1'b1; tick();
    idle_inputs(); wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 8'h55;
    rd_en = 2'b11; tick();
    idle_inputs(); repeat (5) tick();
    read_all();

    // Out-of-range write on the 5-register instance is dropped.
    wr0_en = 1'b1; wr0_addr = 3'd6; wr0_data = 8'h77; tick();
    idle_inputs(); wr1_en = 1'b1; wr1_addr = 3'd7; wr1_data = 8'h99; tick();
    idle_inputs(); read_all();

    // Randomised traffic with occasional clears and one mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      clear    = ($urandom_range(0, 39) == 0);
      wr0_en   = 1'($urandom);
      wr1_en   = ($urandom_range(0, 2) == 0);
      wr0_addr = 3'($urandom);
      wr1_addr = 3'($urandom);
      wr0_data = 8'($urandom);
      wr1_data = 8'($urandom);
      rd_en    = 2'($urandom);
      ra0      = ($urandom_range(0, 1) == 0) ? wr0_addr : 3'($urandom);
      ra1      = ($urandom_range(0, 1) == 0) ? wr1_addr : 3'($urandom);
      if (c == 200) begin
        #2 reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end

    idle_inputs();
    repeat (8) tick();
    read_all();
    repeat (3) tick();

    for (int q = 0; q < 4; q++) begin
      checks++;
      if (exp_rd_q[q].size() != 0) begin
        errors++;
        $display("FAIL pending_reads slot%0d: got %0d outstanding expected 0", q, exp_rd_q[q].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
